// File: rtl/bft_pkg.sv
// rtl/bft_pkg.sv - BFT packet field layout, packing and round-robin pick helpers
package bft_pkg;

  localparam int BFT_PACKET_BITS   = 97;
  localparam int BFT_LEAF_BITS     = 6;
  localparam int BFT_PORT_BITS     = 4;
  localparam int BFT_ADDR_BITS     = 7;
  localparam int BFT_PAYLOAD_BITS  = 64;

  localparam int MAX_CH       = 16;
  localparam int CH_IDX_BITS  = 4;

  // Packet layout, MSB first: valid | leaf | port | reserved | addr | payload
  localparam int PAYLOAD_LSB = 0;
  localparam int ADDR_LSB    = PAYLOAD_LSB + BFT_PAYLOAD_BITS;
  localparam int RSVD_LSB    = ADDR_LSB + BFT_ADDR_BITS;
  localparam int VALID_BIT   = BFT_PACKET_BITS - 1;
  localparam int LEAF_LSB    = VALID_BIT - BFT_LEAF_BITS;
  localparam int PORT_LSB    = LEAF_LSB - BFT_PORT_BITS;
  localparam int RSVD_BITS   = PORT_LSB - RSVD_LSB;

  typedef logic [BFT_PACKET_BITS-1:0] packet_t;

  // Reserved bits stay zero because the packet starts cleared.
  function automatic packet_t pkt_pack(
    input logic [BFT_LEAF_BITS-1:0]    leaf,
    input logic [BFT_PORT_BITS-1:0]    port,
    input logic [BFT_ADDR_BITS-1:0]    addr,
    input logic [BFT_PAYLOAD_BITS-1:0] payload
  );
    packet_t p;
    p = '0;
    p[VALID_BIT]                          = 1'b1;
    p[LEAF_LSB +: BFT_LEAF_BITS]          = leaf;
    p[PORT_LSB +: BFT_PORT_BITS]          = port;
    p[ADDR_LSB +: BFT_ADDR_BITS]          = addr;
    p[PAYLOAD_LSB +: BFT_PAYLOAD_BITS]    = payload;
    return p;
  endfunction

  function automatic logic [CH_IDX_BITS-1:0] rr_pick(
    input logic [MAX_CH-1:0]      elig,
    input logic [CH_IDX_BITS-1:0] ptr,
    input int                     num_ch
  );
    logic [CH_IDX_BITS-1:0] pick;
    logic [CH_IDX_BITS-1:0] idx_b;
    logic                   found;
    int                     idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (i < num_ch && !found) begin
        idx   = (int'(ptr) + i) % num_ch;
        idx_b = idx[CH_IDX_BITS-1:0];
        if (elig[idx_b]) begin
          pick  = idx_b;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered dout and registered full/empty
module sync_fifo #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_BITS = 5
) (
  input  logic             clk_bft,
  input  logic             reset_bft,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wptr;
  logic [DEPTH_BITS-1:0] rptr;
  logic [DEPTH_BITS:0]   count;
  logic [DEPTH_BITS:0]   count_nxt;
  logic                  do_wr;
  logic                  do_rd;

  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_comb begin
    count_nxt = count;
    case ({do_wr, do_rd})
      2'b10:   count_nxt = count + (DEPTH_BITS+1)'(1);
      2'b01:   count_nxt = count - (DEPTH_BITS+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk_bft) begin
    if (reset_bft) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_wr) wptr <= wptr + DEPTH_BITS'(1);
      if (do_rd) rptr <= rptr + DEPTH_BITS'(1);
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_CNT);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk_bft) begin
    if (do_wr) mem[wptr] <= din;
    if (do_rd) dout <= mem[rptr];
  end

endmodule

// File: rtl/output_port_mc.sv
// rtl/output_port_mc.sv - multi-channel BFT leaf output port with credits and round-robin egress
module output_port_mc
  import bft_pkg::*;
#(
  parameter int NUM_CH                = 4,
  parameter int PACKET_BITS           = BFT_PACKET_BITS,
  parameter int NUM_LEAF_BITS         = BFT_LEAF_BITS,
  parameter int NUM_PORT_BITS         = BFT_PORT_BITS,
  parameter int NUM_ADDR_BITS         = BFT_ADDR_BITS,
  parameter int PAYLOAD_BITS          = BFT_PAYLOAD_BITS,
  parameter int FIFO_DEPTH_BITS       = 5,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  localparam int CH_BITS              = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                            clk_bft,
  input  logic                            reset_bft,
  input  logic [CH_BITS-1:0]              cfg_ch,
  input  logic [NUM_ADDR_BITS-1:0]        fifo_addr,
  input  logic [NUM_ADDR_BITS-1:0]        freespace,
  input  logic                            update_fifo_addr_en,
  input  logic                            update_freespace_en,
  input  logic                            add_freespace_en,
  input  logic [NUM_CH*NUM_LEAF_BITS-1:0] dst_leaf,
  input  logic [NUM_CH*NUM_PORT_BITS-1:0] dst_port,
  input  logic                            rd_en_sel,
  output logic [PACKET_BITS-1:0]          internal_out,
  input  logic [NUM_CH-1:0]               vld_user2b_out,
  input  logic [NUM_CH*PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  output logic [NUM_CH-1:0]               ack_b_out2user
);

  typedef logic [NUM_ADDR_BITS-1:0] addr_t;
  typedef logic [NUM_ADDR_BITS:0]   wide_t;

  localparam addr_t CREDIT_MAX = '1;
  localparam wide_t CREDIT_MAX_W = {1'b0, CREDIT_MAX};
  localparam wide_t FS_STEP_W = wide_t'(FREESPACE_UPDATE_SIZE);

  logic [PAYLOAD_BITS-1:0] fifo_dout [NUM_CH];
  logic [NUM_CH-1:0]       fifo_full;
  logic [NUM_CH-1:0]       fifo_empty;
  logic [NUM_CH-1:0]       elig;
  logic [NUM_CH-1:0]       pop;
  logic [NUM_CH-1:0]       cfg_hit;
  logic [MAX_CH-1:0]       elig_w;
  addr_t                   credit [NUM_CH];
  addr_t                   addr   [NUM_CH];
  logic [CH_BITS-1:0]      rr_ptr;
  logic [CH_BITS-1:0]      grant_idx;
  logic [CH_BITS-1:0]      gnt_q;
  logic                    grant_any;
  logic                    out_vld_q;

  // Full is registered, so a push against a full FIFO is refused even if it pops this cycle.
  assign ack_b_out2user = vld_user2b_out & ~fifo_full;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sync_fifo #(
      .WIDTH      (PAYLOAD_BITS),
      .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk_bft   (clk_bft),
      .reset_bft (reset_bft),
      .wr_en     (ack_b_out2user[c]),
      .din       (din_leaf_user2interface[c*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_en     (pop[c]),
      .dout      (fifo_dout[c]),
      .full      (fifo_full[c]),
      .empty     (fifo_empty[c])
    );

    assign elig[c]    = ~fifo_empty[c] & (credit[c] != '0);
    assign pop[c]     = grant_any & (grant_idx == CH_BITS'(c));
    assign cfg_hit[c] = (cfg_ch == CH_BITS'(c));
  end

  always_comb begin
    elig_w             = '0;
    elig_w[NUM_CH-1:0] = elig;
    grant_idx          = CH_BITS'(rr_pick(elig_w, CH_IDX_BITS'(rr_ptr), NUM_CH));
    grant_any          = rd_en_sel & (|elig);
  end

  // Widened by one bit so a refill on top of a near-full credit saturates instead of wrapping.
  function automatic addr_t credit_next(
    input addr_t cur,
    input logic  load,
    input logic  add,
    input logic  take,
    input addr_t ld_val
  );
    wide_t w;
    if (load) return ld_val;
    w = {1'b0, cur};
    if (add)  w = w + FS_STEP_W;
    if (take) w = w - wide_t'(1);
    if (w > CREDIT_MAX_W) return CREDIT_MAX;
    return w[NUM_ADDR_BITS-1:0];
  endfunction

  always_ff @(posedge clk_bft) begin
    if (reset_bft) begin
      rr_ptr    <= '0;
      gnt_q     <= '0;
      out_vld_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        credit[c] <= CREDIT_MAX;
        addr[c]   <= '0;
      end
    end else begin
      out_vld_q <= grant_any;
      if (grant_any) begin
        gnt_q  <= grant_idx;
        rr_ptr <= (grant_idx == CH_BITS'(NUM_CH-1)) ? '0 : grant_idx + CH_BITS'(1);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        credit[c] <= credit_next(credit[c], cfg_hit[c] & update_freespace_en,
                                 cfg_hit[c] & add_freespace_en, pop[c], freespace);
        if (cfg_hit[c] & update_fifo_addr_en)
          addr[c] <= fifo_addr;
        else if (out_vld_q && gnt_q == CH_BITS'(c))
          addr[c] <= addr[c] + addr_t'(1);
      end
    end
  end

  // Every term here is a flop (grant index, FIFO dout, addr), so the packet is out one cycle after grant.
  always_comb begin
    internal_out = '0;
    if (out_vld_q)
      internal_out = pkt_pack(dst_leaf[gnt_q*NUM_LEAF_BITS +: NUM_LEAF_BITS],
                              dst_port[gnt_q*NUM_PORT_BITS +: NUM_PORT_BITS],
                              addr[gnt_q],
                              fifo_dout[gnt_q]);
  end

endmodule

// File: tb/tb_output_port_mc.sv
// tb/tb_output_port_mc.sv - randomized check of output_port_mc against a queue-based model
module tb_output_port_mc;

  localparam int NC = 4;

  logic          clk_bft;
  logic          reset_bft;
  logic [1:0]    cfg_ch;
  logic [6:0]    fifo_addr;
  logic [6:0]    freespace;
  logic          update_fifo_addr_en;
  logic          update_freespace_en;
  logic          add_freespace_en;
  logic [23:0]   dst_leaf;
  logic [15:0]   dst_port;
  logic          rd_en_sel;
  logic [96:0]   internal_out;
  logic [3:0]    vld_user2b_out;
  logic [255:0]  din_leaf_user2interface;
  logic [3:0]    ack_b_out2user;

  output_port_mc #(.NUM_CH(NC)) dut (
    .clk_bft                 (clk_bft),
    .reset_bft               (reset_bft),
    .cfg_ch                  (cfg_ch),
    .fifo_addr               (fifo_addr),
    .freespace               (freespace),
    .update_fifo_addr_en     (update_fifo_addr_en),
    .update_freespace_en     (update_freespace_en),
    .add_freespace_en        (add_freespace_en),
    .dst_leaf                (dst_leaf),
    .dst_port                (dst_port),
    .rd_en_sel               (rd_en_sel),
    .internal_out            (internal_out),
    .vld_user2b_out          (vld_user2b_out),
    .din_leaf_user2interface (din_leaf_user2interface),
    .ack_b_out2user          (ack_b_out2user)
  );

  initial clk_bft = 1'b0;
  always #5 clk_bft = ~clk_bft;

  logic [63:0] mq [NC][$];
  int          m_credit [NC];
  int          m_addr   [NC];
  int          m_rr;
  bit          m_pend;
  int          m_pend_g;
  logic [63:0] m_pend_data;
  bit          m_live;
  logic [5:0]  leaf_tab [NC];
  logic [3:0]  port_tab [NC];
  int          n_checks;
  int          n_errors;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [96:0] model_out();
    if (!m_pend) return '0;
    return {1'b1, leaf_tab[m_pend_g], port_tab[m_pend_g], 15'd0, 7'(m_addr[m_pend_g]), m_pend_data};
  endfunction

  task automatic step(input bit rst, input logic [3:0] vld, input bit rd, input int cch,
                      input bit ua, input bit uf, input bit af, input int fa, input int fs);
    logic [63:0] pay [NC];
    logic [3:0]  exp_ack;
    int          g;
    int          c;
    if (m_live) check_eq("internal_out", internal_out, model_out());
    for (int i = 0; i < NC; i++) begin
      pay[i] = {$urandom, $urandom};
      din_leaf_user2interface[i*64 +: 64] = pay[i];
    end
    reset_bft           = rst;
    vld_user2b_out      = vld;
    rd_en_sel           = rd;
    cfg_ch              = 2'(cch);
    update_fifo_addr_en = ua;
    update_freespace_en = uf;
    add_freespace_en    = af;
    fifo_addr           = 7'(fa);
    freespace           = 7'(fs);
    #1;
    for (int i = 0; i < NC; i++) exp_ack[i] = vld[i] && (mq[i].size() < 32);
    if (m_live) check_eq("ack", ack_b_out2user, exp_ack);

    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        mq[i].delete();
        m_credit[i] = 127;
        m_addr[i]   = 0;
      end
      m_rr   = 0;
      m_pend = 0;
      m_live = 1;
    end else begin
      g = -1;
      if (rd) begin
        for (int i = 0; i < NC; i++) begin
          c = (m_rr + i) % NC;
          if (g < 0 && mq[c].size() > 0 && m_credit[c] > 0) g = c;
        end
      end
      if (m_pend) m_addr[m_pend_g] = (m_addr[m_pend_g] + 1) % 128;
      if (ua) m_addr[cch] = fa;
      for (int i = 0; i < NC; i++) begin
        if (uf && cch == i)
          m_credit[i] = fs;
        else if (af && cch == i)
          m_credit[i] = (m_credit[i] + 64 - ((g == i) ? 1 : 0) > 127) ? 127
                      : m_credit[i] + 64 - ((g == i) ? 1 : 0);
        else if (g == i)
          m_credit[i] = m_credit[i] - 1;
      end
      if (g >= 0) begin
        m_pend_data = mq[g].pop_front();
        m_pend      = 1;
        m_pend_g    = g;
        m_rr        = (g + 1) % NC;
      end else begin
        m_pend = 0;
      end
      for (int i = 0; i < NC; i++)
        if (exp_ack[i]) mq[i].push_back(pay[i]);
    end
    @(posedge clk_bft);
    @(negedge clk_bft);
  endtask

  task automatic idle(input logic [3:0] vld, input bit rd, input int n);
    for (int k = 0; k < n; k++) step(0, vld, rd, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_live   = 0;
    m_pend   = 0;
    m_rr     = 0;
    reset_bft = 1'b1;
    cfg_ch = '0; fifo_addr = '0; freespace = '0;
    update_fifo_addr_en = 0; update_freespace_en = 0; add_freespace_en = 0;
    rd_en_sel = 0; vld_user2b_out = '0; din_leaf_user2interface = '0;
    for (int i = 0; i < NC; i++) begin
      leaf_tab[i] = 6'($urandom);
      port_tab[i] = 4'($urandom);
      dst_leaf[i*6 +: 6] = leaf_tab[i];
      dst_port[i*4 +: 4] = port_tab[i];
    end
    @(negedge clk_bft);
    step(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    step(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);

    // three words on ch0, then drain
    idle(4'b0001, 0, 3);
    idle(4'b0000, 1, 6);

    // two words on every channel, round-robin drain
    idle(4'b1111, 0, 2);
    idle(4'b0000, 1, 10);

    // ch1 credit of one, later refilled
    step(0, 4'b0000, 0, 1, 0, 1, 0, 0, 1);
    idle(4'b0011, 0, 3);
    idle(4'b0000, 1, 8);
    step(0, 4'b0000, 1, 1, 0, 0, 1, 0, 0);
    idle(4'b0000, 1, 6);

    // refill on ch0 racing its own grant must saturate; long run exposes the credit ceiling
    step(0, 4'b0000, 0, 0, 0, 1, 0, 0, 100);
    step(0, 4'b0001, 0, 0, 0, 0, 0, 0, 0);
    step(0, 4'b0001, 1, 0, 0, 0, 1, 0, 0);
    idle(4'b0001, 1, 140);
    step(0, 4'b0000, 1, 0, 0, 0, 1, 0, 0);
    idle(4'b0000, 1, 40);

    // fill ch2 to the brim, then pop while still pushing
    step(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    idle(4'b0100, 0, 34);
    idle(4'b0100, 1, 4);

    // address load colliding with an emission on the same channel
    idle(4'b0010, 0, 2);
    step(0, 4'b0000, 1, 1, 0, 0, 0, 0, 0);
    step(0, 4'b0000, 1, 1, 1, 0, 0, 90, 0);
    idle(4'b0000, 1, 3);

    // reset in the middle of a burst
    idle(4'b1111, 0, 3);
    idle(4'b1111, 1, 2);
    step(1, 4'b0000, 1, 0, 0, 0, 0, 0, 0);
    idle(4'b0000, 1, 3);

    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 199) == 0),
           4'($urandom) & 4'($urandom | $urandom),
           ($urandom_range(0, 9) < 7),
           int'($urandom_range(0, NC-1)),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 127)),
           int'($urandom_range(0, 127)));
    end
    idle(4'b0000, 1, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
